// File: rtl/pulse_pkg.sv
// +----------------------------------------------------------------------------+
// | pulse_pkg: shared state encoding and default counter width for the          |
// | pulse scheduler.                                                            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    HIGH  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CNT_W_DEFAULT = 8;

endpackage

`default_nettype wire

// File: rtl/pulse_scheduler_if.sv
// +----------------------------------------------------------------------------+
// | pulse_scheduler_if: per-requester job handshake bundle (valid/ready plus    |
// | packed delay and width fields).                                             |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface pulse_scheduler_if
  import pulse_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int CNT_W = CNT_W_DEFAULT
);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*CNT_W-1:0] req_delay;
  logic [N_REQ*CNT_W-1:0] req_width;

  modport master (
    output req_valid,
    output req_delay,
    output req_width,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_delay,
    input  req_width,
    output req_ready
  );

endinterface

`default_nettype wire

// File: rtl/pulse_timer.sv
// +----------------------------------------------------------------------------+
// | pulse_timer: loadable down-counter that saturates at zero and flags it.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module pulse_timer #(
  parameter int CNT_W = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_load,
  input  wire logic [CNT_W-1:0] i_load_val,
  input  wire logic             i_dec,
  output logic                  o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/pulse_scheduler.sv
// +----------------------------------------------------------------------------+
// | pulse_scheduler: arbitrates N_REQ (delay, width) jobs onto one pulse output.|
// | Define PULSE_SCHEDULER_RR_EN for round-robin; fixed priority otherwise.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module pulse_scheduler
  import pulse_pkg::*;
#(
  parameter  int N_REQ = 2,
  parameter  int CNT_W = CNT_W_DEFAULT,
  localparam int OW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  wire logic         clk,
  input  wire logic         reset,
  pulse_scheduler_if.slave  req_if,
  output logic              out,
  output logic              busy,
  output logic              done,
  output logic [OW-1:0]     owner
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_width;
  logic [N_REQ-1:0] w_ready;
  logic             w_any;
  logic [OW-1:0]    w_win;
  logic [CNT_W-1:0] w_sel_delay;
  logic [CNT_W-1:0] w_sel_width;
  logic             w_hs;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_dec;
  logic             w_zero;
  int               w_start;

`ifdef PULSE_SCHEDULER_RR_EN
  logic [OW-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= OW'(N_REQ - 1);
    end else if (w_hs) begin
      r_ptr <= w_win;
    end
  end

  assign w_start = int'(r_ptr) + 1;
`else
  assign w_start = 0;
`endif

  // Scan from w_start with wrap; first valid requester wins.
  always_comb begin
    w_any       = 1'b0;
    w_win       = '0;
    w_sel_delay = '0;
    w_sel_width = '0;
    for (int j = 0; j < N_REQ; j++) begin
      int idx;
      idx = (w_start + j) % N_REQ;
      if (!w_any && req_if.req_valid[idx]) begin
        w_any       = 1'b1;
        w_win       = OW'(idx);
        w_sel_delay = req_if.req_delay[idx*CNT_W +: CNT_W];
        w_sel_width = req_if.req_width[idx*CNT_W +: CNT_W];
      end
    end
  end

  always_comb begin
    w_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_ready[i] = (r_state == IDLE) && w_any && (w_win == OW'(i));
    end
  end

  assign req_if.req_ready = w_ready;
  assign w_hs             = |(req_if.req_valid & w_ready);

  // Timer is loaded with count-1 so the phase ends on the cycle it reads zero.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hs) begin
          if (w_sel_delay != '0) begin
            w_load     = 1'b1;
            w_load_val = w_sel_delay - CNT_W'(1);
            w_next     = DELAY;
          end else if (w_sel_width != '0) begin
            w_load     = 1'b1;
            w_load_val = w_sel_width - CNT_W'(1);
            w_next     = HIGH;
          end else begin
            w_next = DONE;
          end
        end
      end
      DELAY: begin
        if (w_zero) begin
          if (r_width != '0) begin
            w_load     = 1'b1;
            w_load_val = r_width - CNT_W'(1);
            w_next     = HIGH;
          end else begin
            w_next = DONE;
          end
        end else begin
          w_dec = 1'b1;
        end
      end
      HIGH: begin
        if (w_zero) begin
          w_next = DONE;
        end else begin
          w_dec = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_width <= '0;
      owner   <= '0;
      out     <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_hs) begin
        r_width <= w_sel_width;
        owner   <= w_win;
      end
      out  <= (w_next == HIGH);
      done <= (w_next == DONE);
      busy <= (w_next != IDLE);
    end
  end

  pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

endmodule

`default_nettype wire

// File: doc/pulse_scheduler.md
# pulse_scheduler

Synthesizable scheduler that shares one pulse output between `N_REQ` requesters. Each requester submits a (delay, width) job over a valid/ready handshake. The block arbitrates between them, then generates a single high pulse of `width` cycles after `delay` idle cycles. It marks completion with a one-cycle `done`. It replaces free-running delay-based pulse stimulus with a clocked, cycle-exact source that sits between test/control sequencers and the pulse consumer.

## Interface
Parameters:
- `N_REQ`, 2, number of requesters (≥1)
- `CNT_W`, 8, width of delay/width fields; max value 2^CNT_W−1

Ports:
- `clk` input 1: sole clock, rising edge
- `reset` input 1: synchronous, active-high
- `req_valid` input N_REQ: per-requester job valid
- `req_ready` output N_REQ: per-requester grant/accept, at most one bit set
- `req_delay` input N_REQ*CNT_W: per-requester delay, slice i = bits [i*CNT_W +: CNT_W]
- `req_width` input N_REQ*CNT_W: per-requester pulse width, same slicing
- `out` output 1: scheduled pulse, registered
- `busy` output 1: high in any state other than IDLE
- `done` output 1: one-cycle completion strobe
- `owner` output max(1,$clog2(N_REQ)): index of the requester owning the current or last job

## Operation
- FSM states: IDLE, DELAY, HIGH, DONE.
- **IDLE**
  - The arbiter picks a winner among the set `req_valid` bits.
  - `req_ready[winner]` is asserted combinationally, in IDLE only.
  - Handshake = `req_valid[i] & req_ready[i]` at a rising edge.
  - On handshake, latch delay, width and `owner`, then go to DELAY.
  - If delay = 0, go to HIGH instead; if delay = 0 and width = 0, go to DONE.
- **DELAY:** `out`=0 for exactly `delay` cycles, then HIGH, or DONE if width = 0.
- **HIGH:** `out`=1 for exactly `width` cycles, then DONE.
- **DONE:** `done`=1 and `out`=0 for one cycle, then IDLE.
- **Requester rules**
  - Requesters hold delay/width stable while valid is high and not yet accepted.
  - Dropping valid before a handshake is legal and discards nothing.
- **Counters**
  - Down-counters are CNT_W wide, loaded from the latched values, and never wrap.
  - Maximum values (2^CNT_W−1) give exactly that many cycles.
- **Reset values:** `out`=0, `busy`=0, `done`=0, `owner`=0, `req_ready` reflects IDLE arbitration, state=IDLE, RR pointer = N_REQ−1 (index 0 highest priority first).
- **Reset mid-operation:** abandons the job. `out` is 0 from the next edge and no `done` is issued.
- **New valid during a job:** it is not accepted until the next IDLE cycle.

## Timing
- Handshake at edge k:
  - `out` high in cycles k+1+delay … k+delay+width.
  - `done` high in cycle k+1+delay+width.
  - IDLE, and the earliest next handshake, in cycle k+2+delay+width.
- Minimum job occupancy is 2 cycles (delay = width = 0): accept cycle, then DONE.
- `busy` is high from cycle k+1 through the DONE cycle inclusive.
- `owner` is updated at edge k and is valid from cycle k+1.

## Configuration
- Macro: `PULSE_SCHEDULER_RR_EN`.
- **Defined:** round-robin arbitration.
  - The search starts at (last granted index + 1) mod N_REQ.
  - The pointer updates only on handshake.
- **Undefined:** fixed priority, lowest set index wins, and no pointer register exists.

## Structure
- Package `pulse_pkg`: state enum type (IDLE, DELAY, HIGH, DONE) and a default `CNT_W` constant.
- Sub-module `pulse_timer`: loadable CNT_W down-counter with a `zero` flag, instantiated once and reused for both the delay and width phases.
- The arbiter lives inline in `pulse_scheduler`.

## Test plan
Configuration: N_REQ=2, CNT_W=8.
- **Basic job:** req0 delay=3, width=2, handshake at cycle 10 → `out` high in cycles 14–15, `done` in cycle 16, `req_ready[0]` re-asserts in cycle 17, `owner`=0.
- **Zero delay:** req1 delay=0, width=1, handshake at cycle 10 → `out` high only in cycle 11, `done` in 12, `owner`=1.
- **Zero width:** req0 delay=2, width=0, handshake at cycle 10 → `out` never high, `done` in cycle 13, `busy` in cycles 11–13.
- **Arbitration:** both valid continuously, each with delay=0, width=1.
  - With `PULSE_SCHEDULER_RR_EN`: grant order 0,1,0,1.
  - Without it: always 0, with `req_ready[1]` never asserted.
- **Reset mid-job:** `reset` asserted for 1 cycle during HIGH → `out`=0 next cycle, no `done`, `owner`=0, IDLE after release, req0 regains first grant.
- **Maximum values:** delay=255, width=255 → `out` high for exactly 255 cycles, starting 256 cycles after the handshake, with no counter wrap.
